// File: rtl/fir_pkg.sv
// Shared widths, default coefficients, FSM states and rounding helpers
// for the sample-strobed X-axis FIR filter.
package fir_pkg;

    localparam int NTAPS_DEF = 16;
    localparam int DATA_W    = 16;
    localparam int COEF_W    = 16;
    localparam int ACC_W     = 40;
    localparam int OUT_W     = 32;
    localparam int FRAC_W    = 15;

    // Adding half an LSB before the arithmetic shift gives round-half-up.
    localparam logic signed [ACC_W-1:0] ROUND_K = 40'sd16384;
    localparam logic signed [ACC_W-1:0] SAT_HI  = 40'sd32767;
    localparam logic signed [ACC_W-1:0] SAT_LO  = -40'sd32768;

    // Q1.15 value 2048 = 1/16, so the default filter is a 16-sample moving average.
    localparam logic [NTAPS_DEF-1:0][COEF_W-1:0] COEF_DEF = {NTAPS_DEF{16'sd2048}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_DONE
    } fir_state_e;

    function automatic logic signed [ACC_W-1:0] fir_round(input logic signed [ACC_W-1:0] acc);
        return (acc + ROUND_K) >>> FRAC_W;
    endfunction

endpackage

// File: rtl/fir_x_filter_if.sv
// Sample-in / result-out bundle between the PIO side and the FIR filter.
interface fir_x_filter_if;

    logic             sample_tick_i;
    logic [31:0]      fir_in_i;
    logic [31:0]      fir_out_o;
    logic             out_valid_o;
    logic             overrun_o;

    modport master (
        output sample_tick_i, fir_in_i,
        input  fir_out_o, out_valid_o, overrun_o
    );

    modport slave (
        input  sample_tick_i, fir_in_i,
        output fir_out_o, out_valid_o, overrun_o
    );

endinterface

// File: rtl/fir_mac.sv
// Signed 16x16 multiplier feeding a 40-bit accumulator with clear and enable.
module fir_mac
    import fir_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [COEF_W-1:0] c,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [DATA_W+COEF_W-1:0] prod;
    logic signed [ACC_W-1:0]         acc_d, acc_q;

    always_comb begin
        prod  = x * c;
        acc_d = acc_q;
        if (clr)
            acc_d = '0;
        else if (en)
            acc_d = acc_q + ACC_W'(prod);
    end

    always_ff @(posedge clk) begin
        if (rst)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

    assign acc = acc_q;

endmodule

// File: rtl/fir_x_filter.sv
// Sequential one-MAC-per-cycle FIR for the X channel, started by a PIO tick.
// Define FIR_SATURATE_EN to clamp the rounded result to 16-bit signed range.
module fir_x_filter
    import fir_pkg::*;
#(
    parameter int                           NTAPS = NTAPS_DEF,
    parameter logic [NTAPS-1:0][COEF_W-1:0] COEF  = COEF_DEF
) (
    input  logic           clk_clk,
    input  logic           reset_reset,
    fir_x_filter_if.slave  bus
);

    localparam int IDX_W = $clog2(NTAPS);

    fir_state_e                   state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [NTAPS-1:0][DATA_W-1:0] dly_q, dly_d;
    logic                         tick_prev_q, tick_prev_d;
    logic                         tick_q, tick_d;
    logic [OUT_W-1:0]             fir_out_q, fir_out_d;
    logic                         out_valid_q, out_valid_d;
    logic                         overrun_q, overrun_d;

    logic                         mac_clr, mac_en;
    logic signed [DATA_W-1:0]     x_new, mac_x;
    logic signed [COEF_W-1:0]     mac_c;
    logic signed [ACC_W-1:0]      acc, r_full;
    logic [OUT_W-1:0]             res;

    // Edge detect is registered, so the FSM acts one edge after the strobe is seen.
    always_comb begin
        tick_prev_d = bus.sample_tick_i;
        tick_d      = bus.sample_tick_i & ~tick_prev_q;
        x_new       = DATA_W'(bus.fir_in_i);
        mac_x       = dly_q[idx_q];
        mac_c       = COEF[idx_q];
        r_full      = fir_round(acc);
`ifdef FIR_SATURATE_EN
        if (r_full > SAT_HI)
            res = OUT_W'(SAT_HI);
        else if (r_full < SAT_LO)
            res = OUT_W'(SAT_LO);
        else
            res = OUT_W'(r_full);
`else
        res = OUT_W'(r_full);
`endif
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        dly_d       = dly_q;
        fir_out_d   = fir_out_q;
        out_valid_d = 1'b0;
        overrun_d   = 1'b0;
        mac_clr     = 1'b0;
        mac_en      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tick_q) begin
                    dly_d   = {dly_q[NTAPS-2:0], x_new};
                    mac_clr = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                idx_d   = '0;
                state_d = S_MAC;
            end
            S_MAC: begin
                mac_en = 1'b1;
                if (idx_q == IDX_W'(NTAPS - 1))
                    state_d = S_DONE;
                else
                    idx_d = idx_q + 1'b1;
            end
            S_DONE: begin
                fir_out_d   = res;
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Busy (including the DONE cycle): the strobe is lost and only flagged.
        if (tick_q && state_q != S_IDLE)
            overrun_d = 1'b1;
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            dly_q       <= '0;
            tick_prev_q <= 1'b0;
            tick_q      <= 1'b0;
            fir_out_q   <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            dly_q       <= dly_d;
            tick_prev_q <= tick_prev_d;
            tick_q      <= tick_d;
            fir_out_q   <= fir_out_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    fir_mac u_mac (
        .clk (clk_clk),
        .rst (reset_reset),
        .clr (mac_clr),
        .en  (mac_en),
        .x   (mac_x),
        .c   (mac_c),
        .acc (acc)
    );

    assign bus.fir_out_o   = fir_out_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.overrun_o   = overrun_q;

endmodule

// File: tb/tb_fir_x_filter.sv
// Directed bench for fir_x_filter: default, 4096-coefficient and 2-tap instances
// share one tick/data stream; each vector checks value and latency of one instance.
`timescale 1ns/1ps
module tb_fir_x_filter;

`ifdef FIR_SATURATE_EN
    localparam int SAT_CAP = 32767;
`else
    localparam int SAT_CAP = 1 << 30;
`endif

    typedef struct {
        logic        rst;
        int          sel;
        logic [15:0] x;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic [31:0] din = '0;

    int          total = 0;
    int          bad   = 0;
    int          sel   = 0;
    logic        s_vld;
    logic [31:0] s_out;
    int          r_lat, r_nv, r_nov;
    logic [31:0] r_val, r_end;
    vec_t        vq[$];

    int step_pos[16] = '{63, 125, 188, 250, 313, 375, 438, 500,
                         563, 625, 688, 750, 813, 875, 938, 1000};
    int step_neg[16] = '{-62, -125, -187, -250, -312, -375, -437, -500,
                         -562, -625, -687, -750, -812, -875, -937, -1000};

    always #5 clk = ~clk;

    fir_x_filter_if if0 ();
    fir_x_filter_if if1 ();
    fir_x_filter_if if2 ();

    assign if0.sample_tick_i = tick;
    assign if0.fir_in_i      = din;
    assign if1.sample_tick_i = tick;
    assign if1.fir_in_i      = din;
    assign if2.sample_tick_i = tick;
    assign if2.fir_in_i      = din;

    fir_x_filter dut0 (
        .clk_clk     (clk),
        .reset_reset (rst),
        .bus         (if0)
    );

    fir_x_filter #(.NTAPS(16), .COEF({16{16'sd4096}})) dut1 (
        .clk_clk     (clk),
        .reset_reset (rst),
        .bus         (if1)
    );

    fir_x_filter #(.NTAPS(2), .COEF({16'sd16384, 16'sd16384})) dut2 (
        .clk_clk     (clk),
        .reset_reset (rst),
        .bus         (if2)
    );

    always_comb begin
        case (sel)
            1:       begin s_vld = if1.out_valid_o; s_out = if1.fir_out_o; end
            2:       begin s_vld = if2.out_valid_o; s_out = if2.fir_out_o; end
            default: begin s_vld = if0.out_valid_o; s_out = if0.fir_out_o; end
        endcase
    end

    function automatic vec_t mk(input logic r, input int s, input int x, input int e, input int l);
        vec_t v;
        v.rst = r;
        v.sel = s;
        v.x   = x[15:0];
        v.exp = e;
        v.lat = l;
        return v;
    endfunction

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, expv);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Raise the tick with sample v; the first posedge after this is E0.
    // Iteration c observes the state after edge E(c-1).
    task automatic run_tick(input logic [15:0] v, input int hold, input int extra_at,
                            input int rst_at, input int win);
        din   = {16'hA5A5, v};
        tick  = 1'b1;
        r_lat = -1;
        r_nv  = 0;
        r_nov = 0;
        r_val = '0;
        for (int c = 1; c <= win; c++) begin
            @(posedge clk);
            #1;
            if (c == hold) tick = 1'b0;
            if (extra_at > 0 && c == extra_at) tick = 1'b1;
            if (extra_at > 0 && c == extra_at + 1) tick = 1'b0;
            if (rst_at > 0 && c == rst_at) rst = 1'b1;
            if (rst_at > 0 && c == rst_at + 1) rst = 1'b0;
            @(negedge clk);
            if (s_vld) begin
                if (r_lat < 0) begin
                    r_lat = c - 1;
                    r_val = s_out;
                end
                r_nv++;
            end
            if (if0.overrun_o) r_nov++;
        end
        r_end = s_out;
    endtask

    initial begin
        // impulse: 16000 then 20 zeros
        vq.push_back(mk(1'b1, 0, 16000, 1000, 19));
        for (int k = 1; k <= 20; k++)
            vq.push_back(mk(1'b0, 0, 0, (k < 16) ? 1000 : 0, 19));
        for (int k = 0; k < 16; k++)
            vq.push_back(mk(k == 0, 0, 1000, step_pos[k], 19));
        for (int k = 0; k < 16; k++)
            vq.push_back(mk(k == 0, 0, -1000, step_neg[k], 19));
        for (int k = 1; k <= 16; k++)
            vq.push_back(mk(k == 1, 1, 30000, (k * 3750 > SAT_CAP) ? SAT_CAP : k * 3750, 19));
        vq.push_back(mk(1'b1, 2, 1000, 500, 5));
        vq.push_back(mk(1'b0, 2, 1000, 1000, 5));
        vq.push_back(mk(1'b0, 2, -1000, 0, 5));
        vq.push_back(mk(1'b0, 2, -1000, -1000, 5));

        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("reset fir_out", if0.fir_out_o, 0);
        chk("reset out_valid", {31'd0, if0.out_valid_o}, 0);
        chk("reset overrun", {31'd0, if0.overrun_o}, 0);
        rst = 1'b0;

        foreach (vq[i]) begin
            if (vq[i].rst) do_reset();
            sel = vq[i].sel;
            run_tick(vq[i].x, 1, 0, 0, 26);
            chk($sformatf("vec%0d value", i), r_val, vq[i].exp);
            chk($sformatf("vec%0d latency", i), r_lat, vq[i].lat);
            chk($sformatf("vec%0d hold", i), r_end, vq[i].exp);
        end

        sel = 0;
        // second tick 5 cycles in lands mid-MAC
        do_reset();
        run_tick(16'd16000, 1, 5, 0, 26);
        chk("ovr_mac value", r_val, 1000);
        chk("ovr_mac pulses", r_nov, 1);
        run_tick(16'd0, 1, 0, 0, 26);
        chk("ovr_mac next value", r_val, 1000);
        chk("ovr_mac next pulses", r_nov, 0);

        // tick sampled while DONE hands back to IDLE
        do_reset();
        run_tick(16'd16000, 1, 18, 0, 26);
        chk("ovr_done value", r_val, 1000);
        chk("ovr_done pulses", r_nov, 1);
        run_tick(16'd0, 1, 0, 0, 26);
        chk("ovr_done next value", r_val, 1000);

        // level held 40 cycles is one tick
        do_reset();
        run_tick(16'd16000, 40, 0, 0, 50);
        chk("level results", r_nv, 1);
        chk("level value", r_val, 1000);
        chk("level overruns", r_nov, 0);
        chk("level hold", r_end, 1000);

        // reset during MAC cycle 7
        do_reset();
        run_tick(16'd5000, 1, 0, 0, 26);
        chk("pre_abort value", r_val, 313);
        run_tick(16'd16000, 1, 0, 9, 26);
        chk("abort results", r_nv, 0);
        chk("abort fir_out", r_end, 0);
        run_tick(16'd16000, 1, 0, 0, 26);
        chk("post_abort value", r_val, 1000);
        chk("post_abort latency", r_lat, 19);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_x_filter.md
FIR_X_FILTER -- requirements
Module: fir_x_filter

Interface
REQ-001 SHALL have parameter NTAPS, default 16, number of filter taps (2..64).
REQ-002 SHALL have parameter COEF, default 16 x 16'sd2048 from fir_pkg, signed Q1.15 coefficients with c[0] applied to the newest sample.
REQ-003 SHALL have port clk_clk, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset_reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port sample_tick_i, input, 1, sample strobe from the NIOS PIO, same clock domain.
REQ-006 SHALL have port fir_in_i, input, 32, raw X sample; bits [15:0] are the signed sample and [31:16] are ignored.
REQ-007 SHALL have port fir_out_o, output, 32, filtered X result, sign-extended and held between updates.
REQ-008 SHALL have port out_valid_o, output, 1, one-cycle pulse when fir_out_o updates.
REQ-009 SHALL have port overrun_o, output, 1, one-cycle pulse when a tick is dropped.

Function
REQ-010 SHALL detect a tick as a rising edge of sample_tick_i (registered previous value); a held-high level SHALL count as one tick.
REQ-011 SHALL implement FSM IDLE -> LOAD -> MAC -> DONE -> IDLE.
REQ-012 In IDLE, on a detected tick, SHALL shift fir_in_i[15:0] into delay-line slot 0 (oldest sample discarded), clear the accumulator, and go to LOAD.
REQ-013 LOAD SHALL last 1 cycle and reset the tap index to 0.
REQ-014 MAC SHALL last exactly NTAPS cycles, each adding x[k]*c[k] (16x16 signed) into a 40-bit signed accumulator.
REQ-015 DONE SHALL compute r = (acc + 2^14) >>> 15 (round half up), drive fir_out_o = r sign-extended or truncated to 32 bits, pulse out_valid_o, and return to IDLE.
REQ-016 Latency: fir_out_o/out_valid_o SHALL update NTAPS+3 clock edges after the edge that samples the tick rising edge.
REQ-017 A tick detected in any state other than IDLE SHALL be dropped, pulse overrun_o, and leave the delay line and the computation unaffected.
REQ-018 A tick in the same cycle as the DONE-to-IDLE transition SHALL be dropped.
REQ-019 The tap index SHALL not wrap; MAC exits when index = NTAPS-1.

Reset
REQ-020 On reset_reset, SHALL within one edge force state=IDLE, delay line=0, accumulator=0, fir_out_o=0, out_valid_o=0, overrun_o=0, and the tick-edge register=0.
REQ-021 Reset mid-MAC SHALL abort the computation with no out_valid_o pulse.
REQ-022 The first tick after reset SHALL see all older samples as zero.

Configuration
REQ-023 With FIR_SATURATE_EN defined, SHALL clamp r to [-32768, 32767] before sign-extension to 32 bits.
REQ-024 Without FIR_SATURATE_EN, SHALL output r's low 32 bits unclamped.

Structure
REQ-025 fir_pkg SHALL hold the default NTAPS, DATA_W=16, COEF_W=16, ACC_W=40, the default coefficient array, the FSM state enum, and the rounding constant.
REQ-026 The multiply-accumulate SHALL be one sub-module, fir_mac (multiplier, accumulator register, clear/enable inputs); delay line and FSM stay in fir_x_filter.

Verification
REQ-027 Impulse test (default params): input 16000, then 20 zero samples -> outputs 1000 for 16 samples, then 0.
REQ-028 Step test: constant 1000 -> output k=1 is 63, k=2 is 125, k=16 onward is 1000; negative step -1000 -> k=16 gives -1000.
REQ-029 Overrun/level test: a tick pulsed 5 cycles after an accepted tick -> overrun_o pulses once and the result is unchanged; sample_tick_i held high for 40 cycles -> exactly one result.
REQ-030 Saturation test: COEF=16 x 4096, constant 30000 for 16 ticks -> 32767 with FIR_SATURATE_EN, 60000 without.
REQ-031 Reset test: reset at MAC cycle 7 -> no out_valid_o and fir_out_o=0; next impulse 16000 -> first output 1000.
REQ-032 Latency test: check that out_valid_o arrives exactly NTAPS+3 edges after the tick edge, for NTAPS=16 and NTAPS=2.
